// File: rtl/length_counter.sv
// Sound-channel length counter: a trigger loads the remaining play time, and
// each enabled length tick counts it down until the channel is silenced.
module length_counter #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] lengthLoad,
    input  logic             trigger,
    input  logic             lengthEnable,
    output logic             chanEnable
);

    localparam logic [WIDTH:0] FULL_LENGTH = (WIDTH + 1)'(1) << WIDTH;
    localparam logic [WIDTH:0] ONE         = (WIDTH + 1)'(1);

    logic [WIDTH:0] cnt;

    // Trigger wins over counting, so the triggering tick never consumes a step;
    // the count parks at zero rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (trigger) begin
            cnt <= FULL_LENGTH - {1'b0, lengthLoad};
        end else if (lengthEnable && (cnt != '0)) begin
            cnt <= cnt - ONE;
        end
    end

    assign chanEnable = (cnt != '0);

endmodule

// File: tb/tb_length_counter.sv
// Self-checking bench for length_counter: directed vector table, hand-written
// corner sequences and a randomized run against a remaining-ticks model.
module tb_length_counter;

    localparam int WIDTH = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] lengthLoad;
    logic             trigger;
    logic             lengthEnable;
    logic             chanEnable;

    int checkCount = 0;
    int errorCount = 0;
    int remaining  = 0;

    typedef struct {
        logic             trig;
        logic             en;
        logic [WIDTH-1:0] load;
        logic             expChan;
    } vec_t;

    vec_t vecs[6];

    length_counter #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lengthLoad   (lengthLoad),
        .trigger      (trigger),
        .lengthEnable (lengthEnable),
        .chanEnable   (chanEnable)
    );

    always #5 clk = ~clk;

    // Drive inputs, take one length tick, and advance the reference model,
    // which tracks how many ticks of play remain.
    task automatic applyStimulus(input logic trig, input logic en, input logic [WIDTH-1:0] load);
        trigger      = trig;
        lengthEnable = en;
        lengthLoad   = load;
        @(posedge clk);
        #1;
        if (trig)
            remaining = (1 << WIDTH) - int'(load);
        else if (en && remaining > 0)
            remaining = remaining - 1;
    endtask

    task automatic checkOutput(input string name, input logic expected);
        checkCount++;
        if (chanEnable !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: chanEnable=%0b expected %0b (t=%0t)", name, chanEnable, expected, $time);
        end
    endtask

    task automatic pulseReset();
        #2 rst_n = 1'b0;
        #1;
        remaining = 0;
        checkOutput("resetAsync", 1'b0);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 6'd61, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 6'd5,  1'b1};
        vecs[2] = '{1'b0, 1'b1, 6'd61, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 6'd61, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 6'd61, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 6'd61, 1'b0};

        trigger      = 1'b0;
        lengthEnable = 1'b1;
        lengthLoad   = 6'd63;
        rst_n        = 1'b0;
        #12;
        checkOutput("resetHeld", 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 6'd63);
            checkOutput("afterReset", 1'b0);
        end

        // Short count (period 3), including a lengthLoad change mid-count
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].trig, vecs[i].en, vecs[i].load);
            checkOutput($sformatf("shortCount[%0d]", i), vecs[i].expChan);
        end

        // Full length with lengthLoad = 0
        applyStimulus(1'b1, 1'b1, 6'd0);
        checkOutput("fullTrigger", 1'b1);
        for (int i = 1; i <= 63; i++) begin
            applyStimulus(1'b0, 1'b1, 6'd0);
            checkOutput($sformatf("fullEdge%0d", i), 1'b1);
        end
        applyStimulus(1'b0, 1'b1, 6'd0);
        checkOutput("fullEdge64", 1'b0);

        // Hold while lengthEnable is low
        applyStimulus(1'b1, 1'b1, 6'd60);
        checkOutput("holdTrigger", 1'b1);
        applyStimulus(1'b0, 1'b1, 6'd60);
        applyStimulus(1'b0, 1'b1, 6'd60);
        checkOutput("holdCounted", 1'b1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 6'd0);
            checkOutput("holdFrozen", 1'b1);
        end
        applyStimulus(1'b0, 1'b1, 6'd60);
        checkOutput("holdResume1", 1'b1);
        applyStimulus(1'b0, 1'b1, 6'd60);
        checkOutput("holdResume2", 1'b0);

        // Retrigger restarts from the new value
        applyStimulus(1'b1, 1'b1, 6'd62);
        applyStimulus(1'b0, 1'b1, 6'd62);
        checkOutput("retrigFirst", 1'b1);
        applyStimulus(1'b1, 1'b1, 6'd60);
        checkOutput("retrigEdge", 1'b1);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b0, 1'b1, 6'd60);
            checkOutput($sformatf("retrigEdge%0d", i), 1'b1);
        end
        applyStimulus(1'b0, 1'b1, 6'd60);
        checkOutput("retrigEdge4", 1'b0);

        // Mid-count reset
        applyStimulus(1'b1, 1'b1, 6'd32);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 6'd32);
        checkOutput("midCountBefore", 1'b1);
        pulseReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 6'd32);
            checkOutput("midCountAfter", 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 6'd63);
        checkOutput("triggerNoEnable", 1'b1);
        applyStimulus(1'b0, 1'b1, 6'd63);
        checkOutput("singleTickExpire", 1'b0);

        // Randomized run against the remaining-ticks model
        for (int i = 0; i < 2000; i++) begin
            applyStimulus(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                          WIDTH'($urandom_range(40, 63)));
            checkOutput("random", (remaining != 0));
            if ($urandom_range(0, 199) == 0) pulseReset();
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
